// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR port. Executes Zicsr instructions
// (CSRRW/CSRRS/CSRRC and their immediate forms) as a fixed read, modify, write
// sequence, then returns the old CSR value for rd writeback.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_*                  decoded CSR instruction from the decoder (valid/ready)
//   flush_i                pipeline kill, returns the unit to idle
//   csr_ren_o/raddr_o      CSR read strobe/address, csr_rdata_i returns same cycle
//   csr_wen_o/waddr_o/wdata_o  CSR write strobe/address/data
//   resp_*                 rd writeback result (valid/ready)
//   illegal_valid_o        one-cycle illegal-access pulse with illegal_trap_id_o
//   busy_o                 high whenever the unit is not idle; stalls the pipeline
module csr_access_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ILLEGAL_ID = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [11:0]     req_csr_addr_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  input  logic [4:0]      req_rd_idx_i,
  input  logic            flush_i,
  output logic            csr_ren_o,
  output logic [11:0]     csr_raddr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [4:0]      resp_rd_idx_o,
  output logic            resp_rd_wen_o,
  output logic [XLEN-1:0] resp_rd_data_o,
  output logic            illegal_valid_o,
  output logic [5:0]      illegal_trap_id_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StResp, StIll} state_e;

  state_e          state_q;
  logic [1:0]      funct3_q;   // only the op-select bits are needed after accept
  logic [11:0]     addr_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] old_q;
  logic            do_read_q;
  logic            do_write_q;

  logic            accept;
  logic            in_write;
  logic            in_read;
  logic            in_illegal;
  logic [XLEN-1:0] in_operand;
  logic [XLEN-1:0] wdata;

  // Accept-time decode. CSRRS/CSRRC with rs1=x0 do not write; CSRRW with rd=x0
  // does not read (no read side effects).
  assign accept     = req_valid_i & req_ready_o;
  assign in_write   = (req_funct3_i[1:0] == 2'b01) | (req_rs1_idx_i != 5'd0);
  assign in_read    = (req_funct3_i[1:0] != 2'b01) | (req_rd_idx_i != 5'd0);
  // addr[11:10]==11 marks a read-only CSR.
  assign in_illegal = (req_funct3_i[1:0] == 2'b00) |
                      (in_write & (req_csr_addr_i[11:10] == 2'b11));
  assign in_operand = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      funct3_q   <= '0;
      addr_q     <= '0;
      rd_idx_q   <= '0;
      op_q       <= '0;
      old_q      <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
    end else if ((state_q != StIdle) && flush_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            funct3_q   <= req_funct3_i[1:0];
            addr_q     <= req_csr_addr_i;
            rd_idx_q   <= req_rd_idx_i;
            op_q       <= in_operand;
            do_read_q  <= in_read;
            do_write_q <= in_write;
            state_q    <= in_illegal ? StIll : StRead;
          end
        end
        StRead: begin
          old_q   <= do_read_q ? csr_rdata_i : '0;
          state_q <= StWrite;
        end
        StWrite: state_q <= StResp;
        StResp:  if (resp_ready_i) state_q <= StIdle;
        StIll:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (funct3_q)
      2'b10:   wdata = old_q | op_q;
      2'b11:   wdata = old_q & ~op_q;
      default: wdata = op_q;
    endcase
  end

  // Outputs depend only on registered state and latched fields; flush_i only
  // gates req_ready and the write strobe.
  always_comb begin
    req_ready_o       = (state_q == StIdle) & ~flush_i;
    busy_o            = (state_q != StIdle);
    csr_ren_o         = 1'b0;
    csr_raddr_o       = '0;
    csr_wen_o         = 1'b0;
    csr_waddr_o       = '0;
    csr_wdata_o       = '0;
    resp_valid_o      = 1'b0;
    resp_rd_idx_o     = '0;
    resp_rd_wen_o     = 1'b0;
    resp_rd_data_o    = '0;
    illegal_valid_o   = 1'b0;
    illegal_trap_id_o = '0;
    unique case (state_q)
      StRead: begin
        csr_ren_o = do_read_q;
        if (do_read_q) csr_raddr_o = addr_q;
      end
      StWrite: begin
        csr_wen_o = do_write_q & ~flush_i;
        if (csr_wen_o) begin
          csr_waddr_o = addr_q;
          csr_wdata_o = wdata;
        end
      end
      StResp: begin
        resp_valid_o   = 1'b1;
        resp_rd_idx_o  = rd_idx_q;
        resp_rd_wen_o  = (rd_idx_q != 5'd0);
        resp_rd_data_o = old_q;
      end
      StIll: begin
        illegal_valid_o   = 1'b1;
        illegal_trap_id_o = 6'(ILLEGAL_ID);
      end
      default: ;
    endcase
  end

endmodule
